// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier:
// the controller state encoding and the Booth digit codes.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    RESOLVE = 2'b10,
    DONE    = 2'b11
  } state_t;

  // Digit code bits are {neg, two, one}, so a code maps directly onto
  // the select lines of the partial-product mux.
  typedef enum logic [2:0] {
    ZERO = 3'b000,
    P1   = 3'b001,
    P2   = 3'b010,
    M1   = 3'b101,
    M2   = 3'b110
  } digit_t;

  // Radix-4 Booth recoding of the window {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t booth_digit(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_enc.sv
// Booth digit encoder: turns a 3-bit multiplier window into the
// neg/one/two select lines that steer the partial-product mux.
module booth_enc
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic       neg,
  output logic       one,
  output logic       two
);

  // Decode the recoded digit into one-hot magnitude plus a sign line.
  always_comb begin
    neg = 1'b0;
    one = 1'b0;
    two = 1'b0;
    case (booth_digit(win))
      P1: one = 1'b1;
      P2: two = 1'b1;
      M1: begin
        neg = 1'b1;
        one = 1'b1;
      end
      M2: begin
        neg = 1'b1;
        two = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq_ctrl.sv
// Sequential radix-4 Booth multiplier. One Booth digit per clock is
// folded into a redundant (sum, carry) accumulator by a single 3:2
// compression row; one carry-propagate add resolves the product.
module booth_mul_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PPW  = WIDTH + 2;
  localparam int NDIG = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    sum_q, carry_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   b_pad;
  logic [2:0]       win;
  logic             neg, one, two;
  logic [PPW-1:0]   a_ext, mag, pp;
  logic [PW-1:0]    pp_sh, carry_sh, sum_next, carry_next;
  logic             last_digit;

  // The implicit b[-1]=0 is appended below bit 0, so digit i's window
  // starts at bit 2i of the padded multiplier.
  assign b_pad = {b_q, 1'b0};
  assign win   = 3'(b_pad >> {cnt_q, 1'b0});

  booth_enc u_enc (
    .win (win),
    .neg (neg),
    .one (one),
    .two (two)
  );

  // Two guard bits keep +/-2A exact, including -2 * -2^(WIDTH-1).
  assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};
  assign mag   = two ? {a_ext[PPW-2:0], 1'b0} : (one ? a_ext : '0);
  assign pp    = neg ? -mag : mag;

  // Carry is stored at its own bit weight; it is doubled when consumed.
  assign pp_sh      = {{(PW-PPW){pp[PPW-1]}}, pp} << {cnt_q, 1'b0};
  assign carry_sh   = {carry_q[PW-2:0], 1'b0};
  assign sum_next   = sum_q ^ carry_sh ^ pp_sh;
  assign carry_next = (sum_q & carry_sh) | (sum_q & pp_sh) | (carry_sh & pp_sh);
  assign last_digit = (cnt_q == CW'(NDIG - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == RESOLVE);

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: accept, run NDIG digits, resolve once, then hold.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_digit) state_next = RESOLVE;
      RESOLVE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, digit accumulation and the final add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= carry_next;
          cnt_q   <= cnt_q + CW'(1);
        end
        RESOLVE: product <= sum_q + carry_sh;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq_ctrl.sv
// Self-checking bench for booth_mul_seq_ctrl (WIDTH=16): directed vector
// table, back-pressure and mid-run reset sequences, then a randomized run
// scored against a plain a*b reference model.
module tb_booth_mul_seq_ctrl;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  vec_t vecs[9];

  booth_mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands until accepted; returns one cycle after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] aa, input logic [W-1:0] bb);
    int n;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Count cycles from the accept (cycle 1 = first cycle after accept edge).
  task automatic waitResult(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int cyc;
    int got;
    int acc;
    int budget;
    logic signed [W-1:0] sa, sb;
    longint p;
    logic [2*W-1:0] e;
    logic [2*W-1:0] q[$];

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[2] = '{16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[3] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[4] = '{16'h0000, 16'hFFFF, 32'h00000000};
    vecs[5] = '{16'h8000, 16'h0002, 32'hFFFF0000};
    vecs[6] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    vecs[7] = '{16'hFFFE, 16'hFFFE, 32'h00000004};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    #13;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    #9 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput("busy_after_accept", 64'(busy), 64'd1);
      checkOutput("in_ready_after_accept", 64'(in_ready), 64'd0);
      waitResult(cyc);
      checkOutput("latency", 64'(cyc), 64'd10);
      checkOutput("vec_product", 64'(product), 64'(vecs[i].prod));
      @(posedge clk); #1;
      checkOutput("in_ready_after_handshake", 64'(in_ready), 64'd1);
      checkOutput("out_valid_after_handshake", 64'(out_valid), 64'd0);
      checkOutput("product_held", 64'(product), 64'(vecs[i].prod));
    end

    $display("[TB] output back-pressure");
    out_ready = 1'b0;
    applyStimulus(16'hFFF9, 16'h0009);
    waitResult(cyc);
    checkOutput("stall_latency", 64'(cyc), 64'd10);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_product", 64'(product), 64'h00000000FFFFFFC1);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checkOutput("stall_hs_out_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_hs_product", 64'(product), 64'h00000000FFFFFFC1);
    @(posedge clk); #1;
    checkOutput("stall_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("stall_release_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] reset during RUN");
    applyStimulus(16'd100, 16'd200);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_product", 64'(product), 64'd0);
    checkOutput("midrun_reset_in_ready", 64'(in_ready), 64'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(16'hFFFD, 16'hFFFD);
    waitResult(cyc);
    checkOutput("post_reset_latency", 64'(cyc), 64'd10);
    checkOutput("post_reset_product", 64'(product), 64'h0000000000000009);
    @(posedge clk); #1;

    $display("[TB] randomized run against reference model");
    got = 0;
    acc = 0;
    budget = 0;
    in_valid = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    while (got < 2000 && budget < 60000) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        sa = a;
        sb = b;
        p = longint'(sa) * longint'(sb);
        q.push_back(p[2*W-1:0]);
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_duplicate: got 0x%0h with no operation outstanding, expected none", product);
        end else begin
          e = q.pop_front();
          checkOutput("rand_product", 64'(product), 64'(e));
        end
        got++;
      end
      @(posedge clk); #1;
      budget++;
      in_valid = (acc < 2000);
      a = W'($urandom);
      b = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("rand_result_count", 64'(got), 64'd2000);
    checkOutput("rand_accept_count", 64'(acc), 64'd2000);
    checkOutput("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
